// File: rtl/vertex_assembler.sv
// Gathers the serial x/y/z/w component stream into whole vertices and queues
// them in a show-ahead FIFO for the rasterizer setup stage, flagging dropped vertices.
module vertex_assembler #(
  parameter int M     = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [M-1:0]             in_component,
  input  logic                     in_component_valid,
  input  logic                     flush,
  output logic [M-1:0]             out_x,
  output logic [M-1:0]             out_y,
  output logic [M-1:0]             out_z,
  output logic [M-1:0]             out_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     overflow_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]     idx_q, idx_d;
  logic [M-1:0]   slot0_q, slot1_q, slot2_q;
  logic [PW-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           sticky_q, sticky_d;
  logic [4*M-1:0] mem_q [DEPTH];
  logic [4*M-1:0] head;

  logic beat, push, pop, full, doWrite, drop;

  // Flush wins over every data-path event in its cycle, so gate beats and pops here.
  assign beat    = in_component_valid && !flush;
  assign push    = beat && (idx_q == 2'd3);
  assign pop     = out_valid && out_ready && !flush;
  assign full    = (count_q == CW'(DEPTH));
  assign doWrite = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    idx_d      = idx_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = drop;
    sticky_d   = sticky_q | drop;
    if (flush) begin
      idx_d      = 2'd0;
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      sticky_d   = 1'b0;
    end else begin
      if (beat)    idx_d   = idx_q + 2'd1;
      if (doWrite) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)     rdPtr_d = rdPtr_q + PW'(1);
      case ({doWrite, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q      <= 2'd0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      sticky_q   <= sticky_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      slot2_q <= '0;
    end else if (beat) begin
      case (idx_q)
        2'd0:    slot0_q <= in_component;
        2'd1:    slot1_q <= in_component;
        2'd2:    slot2_q <= in_component;
        default: ;
      endcase
    end
  end

  // The w component goes straight into the FIFO entry, bypassing the slots.
  always_ff @(posedge clk) begin
    if (doWrite) mem_q[wrPtr_q] <= {slot0_q, slot1_q, slot2_q, in_component};
  end

  assign head = mem_q[rdPtr_q];

  always_comb begin
    out_valid       = (count_q != '0);
    level           = count_q;
    overflow        = overflow_q;
    overflow_sticky = sticky_q;
    out_x           = '0;
    out_y           = '0;
    out_z           = '0;
    out_w           = '0;
    if (out_valid) begin
      out_x = head[4*M-1:3*M];
      out_y = head[3*M-1:2*M];
      out_z = head[2*M-1:M];
      out_w = head[M-1:0];
    end
  end

endmodule

// File: tb/tb_vertex_assembler.sv
// Directed self-checking bench for vertex_assembler: assembly, gaps, overflow,
// full-with-pop and pointer wrap, flush and asynchronous reset.
module tb_vertex_assembler;

  localparam int M     = 11;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic           clk;
  logic           reset_n;
  logic [M-1:0]   in_component;
  logic           in_component_valid;
  logic           flush;
  logic [M-1:0]   out_x, out_y, out_z, out_w;
  logic           out_valid;
  logic           out_ready;
  logic [LW-1:0]  level;
  logic           overflow;
  logic           overflow_sticky;

  int vectors;
  int miscompares;

  vertex_assembler #(.M(M), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_component       (in_component),
    .in_component_valid (in_component_valid),
    .flush              (flush),
    .out_x              (out_x),
    .out_y              (out_y),
    .out_z              (out_z),
    .out_w              (out_w),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .level              (level),
    .overflow           (overflow),
    .overflow_sticky    (overflow_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*M-1:0] vtx(input int x, input int y, input int z, input int w);
    return {M'(x), M'(y), M'(z), M'(w)};
  endfunction

  // Component c of numbered vertex k, alternating signs.
  function automatic int comp(input int k, input int c);
    case (c)
      0:       return k * 10;
      1:       return -(k * 10 + 1);
      2:       return k * 10 + 2;
      default: return -(k * 10 + 3);
    endcase
  endfunction

  function automatic logic [4*M-1:0] vk(input int k);
    return vtx(comp(k, 0), comp(k, 1), comp(k, 2), comp(k, 3));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input int value);
    in_component       = M'(value);
    in_component_valid = 1'b1;
    tick();
    in_component_valid = 1'b0;
  endtask

  task automatic sendVertex(input int x, input int y, input int z, input int w);
    int v[4];
    v = '{x, y, z, w};
    for (int c = 0; c < 4; c++) begin
      in_component       = M'(v[c]);
      in_component_valid = 1'b1;
      tick();
    end
    in_component_valid = 1'b0;
  endtask

  task automatic popOne();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    vectors++;
    if ({out_valid, level, overflow, overflow_sticky} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got valid=%0b level=%0d ovf=%0b sticky=%0b, want all 0",
               out_valid, level, overflow, overflow_sticky);
    end
    vectors++;
    if ({out_x, out_y, out_z, out_w} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h, want 0", {out_x, out_y, out_z, out_w});
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [4*M-1:0] exp;
    exp = vtx(10, -20, 30, 1);
    out_ready = 1'b0;
    sendVertex(10, -20, 30, 1);
    for (int i = 0; i <= 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || level !== LW'(1) || {out_x, out_y, out_z, out_w} !== exp) begin
        miscompares++;
        $display("[TB] FAIL single_hold%0d: got valid=%0b level=%0d data=%h, want valid=1 level=1 data=%h",
                 i, out_valid, level, {out_x, out_y, out_z, out_w}, exp);
      end
      if (i < 5) tick();
    end
    popOne();
    vectors++;
    if (out_valid !== 1'b0 || level !== LW'(0)) begin
      miscompares++;
      $display("[TB] FAIL single_pop: got valid=%0b level=%0d, want valid=0 level=0", out_valid, level);
    end
  endtask

  task automatic test_gapped();
    int beats[4];
    logic [4*M-1:0] exp;
    beats = '{-1024, 1023, 0, -1};
    exp   = vtx(-1024, 1023, 0, -1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(beats[c]);
      idle(3);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL gapped_early%0d: got valid=%0b, want 0", c, out_valid);
      end
    end
    applyStimulus(beats[3]);
    vectors++;
    if (out_valid !== 1'b1 || {out_x, out_y, out_z, out_w} !== exp) begin
      miscompares++;
      $display("[TB] FAIL gapped_vertex: got valid=%0b data=%h, want valid=1 data=%h",
               out_valid, {out_x, out_y, out_z, out_w}, exp);
    end
    popOne();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      sendVertex(comp(k, 0), comp(k, 1), comp(k, 2), comp(k, 3));
      vectors++;
      if (level !== LW'(k > DEPTH ? DEPTH : k) || overflow !== (k > DEPTH)) begin
        miscompares++;
        $display("[TB] FAIL ovf_fill%0d: got level=%0d ovf=%0b, want level=%0d ovf=%0b",
                 k, level, overflow, (k > DEPTH ? DEPTH : k), (k > DEPTH));
      end
    end
    vectors++;
    if (overflow_sticky !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_sticky: got %0b, want 1", overflow_sticky);
    end
    tick();
    vectors++;
    if (overflow !== 1'b0 || overflow_sticky !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_pulse_end: got ovf=%0b sticky=%0b, want ovf=0 sticky=1", overflow, overflow_sticky);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || {out_x, out_y, out_z, out_w} !== vk(k)) begin
        miscompares++;
        $display("[TB] FAIL ovf_drain%0d: got valid=%0b data=%h, want valid=1 data=%h",
                 k, out_valid, {out_x, out_y, out_z, out_w}, vk(k));
      end
      popOne();
    end
    vectors++;
    if (out_valid !== 1'b0 || level !== LW'(0)) begin
      miscompares++;
      $display("[TB] FAIL ovf_empty: got valid=%0b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    sendVertex(comp(1, 0), comp(1, 1), comp(1, 2), comp(1, 3));
    sendVertex(comp(2, 0), comp(2, 1), comp(2, 2), comp(2, 3));
    applyStimulus(1);
    applyStimulus(2);
    vectors++;
    if (level !== LW'(2) || overflow_sticky !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_pre: got level=%0d sticky=%0b, want level=2 sticky=1", level, overflow_sticky);
    end
    flush              = 1'b1;
    out_ready          = 1'b1;
    in_component       = M'(77);
    in_component_valid = 1'b1;
    tick();
    flush              = 1'b0;
    out_ready          = 1'b0;
    in_component_valid = 1'b0;
    vectors++;
    if (level !== LW'(0) || out_valid !== 1'b0 || overflow_sticky !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_clear: got level=%0d valid=%0b sticky=%0b ovf=%0b, want all 0",
               level, out_valid, overflow_sticky, overflow);
    end
    sendVertex(5, 6, 7, 8);
    vectors++;
    if (level !== LW'(1) || {out_x, out_y, out_z, out_w} !== vtx(5, 6, 7, 8)) begin
      miscompares++;
      $display("[TB] FAIL flush_after: got level=%0d data=%h, want level=1 data=%h",
               level, {out_x, out_y, out_z, out_w}, vtx(5, 6, 7, 8));
    end
    popOne();
  endtask

  task automatic test_full_pop();
    int expNext;
    expNext   = 1;
    out_ready = 1'b0;
    for (int k = 1; k <= DEPTH; k++) sendVertex(comp(k, 0), comp(k, 1), comp(k, 2), comp(k, 3));
    for (int k = DEPTH + 1; k <= 3 * DEPTH; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k == DEPTH + 1 && c == 3) out_ready = 1'b1;
        if (out_valid && out_ready) begin
          vectors++;
          if ({out_x, out_y, out_z, out_w} !== vk(expNext)) begin
            miscompares++;
            $display("[TB] FAIL wrap_order%0d: got %h, want %h", expNext, {out_x, out_y, out_z, out_w}, vk(expNext));
          end
          expNext++;
        end
        in_component       = M'(comp(k, c));
        in_component_valid = 1'b1;
        tick();
        if (k == DEPTH + 1 && c == 3) begin
          vectors++;
          if (overflow !== 1'b0 || level !== LW'(DEPTH)) begin
            miscompares++;
            $display("[TB] FAIL full_pop: got ovf=%0b level=%0d, want ovf=0 level=%0d", overflow, level, DEPTH);
          end
        end
      end
    end
    in_component_valid = 1'b0;
    for (int i = 0; i < 20 && out_valid; i++) begin
      vectors++;
      if ({out_x, out_y, out_z, out_w} !== vk(expNext)) begin
        miscompares++;
        $display("[TB] FAIL wrap_order%0d: got %h, want %h", expNext, {out_x, out_y, out_z, out_w}, vk(expNext));
      end
      expNext++;
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (expNext !== 3 * DEPTH + 1 || out_valid !== 1'b0 || overflow_sticky !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wrap_total: got drained=%0d valid=%0b sticky=%0b, want drained=%0d valid=0 sticky=0",
               expNext - 1, out_valid, overflow_sticky, 3 * DEPTH);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) sendVertex(comp(k, 0), comp(k, 1), comp(k, 2), comp(k, 3));
    applyStimulus(1);
    applyStimulus(2);
    vectors++;
    if (level !== LW'(3)) begin
      miscompares++;
      $display("[TB] FAIL areset_pre: got level=%0d, want 3", level);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, level, overflow, overflow_sticky} !== '0 || {out_x, out_y, out_z, out_w} !== '0) begin
      miscompares++;
      $display("[TB] FAIL areset_now: got valid=%0b level=%0d ovf=%0b sticky=%0b data=%h, want all 0",
               out_valid, level, overflow, overflow_sticky, {out_x, out_y, out_z, out_w});
    end
    tick();
    reset_n = 1'b1;
    tick();
    sendVertex(21, 22, 23, 24);
    vectors++;
    if (level !== LW'(1) || out_valid !== 1'b1 || {out_x, out_y, out_z, out_w} !== vtx(21, 22, 23, 24)) begin
      miscompares++;
      $display("[TB] FAIL areset_after: got level=%0d valid=%0b data=%h, want level=1 valid=1 data=%h",
               level, out_valid, {out_x, out_y, out_z, out_w}, vtx(21, 22, 23, 24));
    end
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    reset_n            = 1'b0;
    in_component       = '0;
    in_component_valid = 1'b0;
    flush              = 1'b0;
    out_ready          = 1'b0;
    test_reset();
    test_single();
    test_gapped();
    test_overflow();
    test_flush();
    test_full_pop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vertex_assembler.md
# vertex_assembler

Receive-side companion to the vertex transform stage. Collects the serial stream of transformed components (x, y, z, w on consecutive valid beats, M-bit signed integers) into whole parallel vertices. Buffers them in a small FIFO and presents them to the rasterizer setup stage over a valid/ready handshake. The upstream transform stage has no backpressure, so this block also detects and flags dropped vertices.

## Interface

Parameters:
- M, 11, component width in bits (signed integer, post-shift output of the transform stage)
- DEPTH, 4, FIFO capacity in whole vertices; power of two, ≥2

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- reset_n  input  1  asynchronous, active-low reset
- in_component  input  M  signed component; order x, y, z, w
- in_component_valid  input  1  in_component is valid this cycle
- flush  input  1  synchronous clear of the partial vertex and the FIFO
- out_x, out_y, out_z, out_w  output  M each  signed components of the FIFO head vertex
- out_valid  output  1  FIFO non-empty; out_* hold a vertex
- out_ready  input  1  downstream accepts the head vertex when out_valid && out_ready
- level  output  $clog2(DEPTH)+1  number of vertices in the FIFO, 0..DEPTH
- overflow  output  1  one-cycle pulse when a completed vertex is dropped
- overflow_sticky  output  1  set by any drop; cleared only by reset or flush

## Operation

- 2-bit component index `idx`, reset 0. Each cycle with in_component_valid high:
  - latches in_component into assembly slot idx;
  - increments idx, wrapping 3→0.
- Gaps are allowed: with in_component_valid low, idx and the assembly slots hold. There is no timeout.
- On the beat where idx==3, the vertex {slot0, slot1, slot2, in_component} is written into the FIFO at that same edge. The w component bypasses the assembly register.
- FIFO: DEPTH entries of 4·M bits, with read pointer, write pointer and a separate count.
  - push = completed vertex this cycle.
  - pop = out_valid && out_ready.
- Full FIFO (level==DEPTH):
  - push with pop in the same cycle: both happen, level is unchanged, no overflow.
  - push without pop: the vertex is discarded and the FIFO is untouched. overflow is high for the following cycle and overflow_sticky is set.
- Empty FIFO: pop is impossible because out_valid is 0. out_ready is ignored.
- out_* always show the head entry (show-ahead).
  - While out_valid && !out_ready, out_* and out_valid must stay stable.
  - Contents when out_valid=0 are don't-care; the bench checks them only when valid.
- flush (synchronous; lower priority than reset, higher than everything else):
  - idx ← 0, FIFO emptied (level ← 0, out_valid ← 0);
  - overflow ← 0, overflow_sticky ← 0;
  - a component presented in the flush cycle is discarded, and a pop in that cycle has no effect.
- Arithmetic: none on the data. Components pass bit-exact, sign preserved; no saturation or shifting.

## Timing

- Reset (asynchronous, on reset_n low): idx=0, level=0, out_valid=0, overflow=0, overflow_sticky=0, out_x/y/z/w=0, pointers=0. Effective immediately, mid-vertex or mid-burst. Normal operation resumes on the first rising edge after reset_n is high.
- Latency: w accepted at edge T into an empty FIFO gives out_valid=1 and correct out_* after edge T, i.e. visible in cycle T+1.
- Throughput: one vertex per 4 input beats sustained, with no bubbles needed.
- A pop at edge T shows the next entry, or out_valid=0, from cycle T+1.
- level updates at the same edge as push/pop: +1 for push only, −1 for pop only, 0 for both or neither.
- overflow is registered: high exactly one cycle, the cycle after the dropped w beat. Back-to-back drops give a pulse every 4 beats.
- Pointer wrap-around at DEPTH is seamless and must not corrupt ordering.

## Test plan

- Single vertex: beats 10, −20, 30, 1 on consecutive cycles, out_ready=0. Next cycle: out_valid=1, out_x=10, out_y=−20, out_z=30, out_w=1, level=1. They stay stable for 5 idle cycles. Raising out_ready pops: out_valid=0, level=0.
- Gapped input and extremes: components −1024, 1023, 0, −1 with 3 idle cycles between beats. The vertex appears only after the 4th beat, values bit-exact (sign preserved at M=11).
- Overflow: out_ready=0, feed DEPTH+1=5 vertices. level saturates at 4; the 5th vertex produces a single overflow pulse and overflow_sticky=1. Draining afterwards returns vertices 1–4 in order; the 5th never appears.
- Full with simultaneous pop: FIFO at 4, out_ready=1 on the cycle of the 5th w beat. Required: no overflow, level stays 4, and all 5 vertices drain in order. Continue to 3·DEPTH vertices to exercise pointer wrap.
- Flush mid-vertex: send x=1, y=2, then assert flush for 1 cycle with FIFO holding 2 vertices and sticky set. Required: level=0, out_valid=0, overflow_sticky=0. Then beats 5, 6, 7, 8 yield exactly the vertex (5, 6, 7, 8).
- Asynchronous reset mid-operation: drive reset_n low between edges after 2 components with 3 vertices buffered. All outputs go to 0 immediately. After release, a fresh 4-beat vertex is assembled from idx 0.
